// File: rtl/mmu_pkg.sv
// mmu_pkg: shared definitions for the matrix-multiply output stage.
//   state_t     - FSM encoding (IDLE / ACCUM / DRAIN)
//   ACC_OFFSET  - default headroom bits of an accumulator lane over a psum
//   sext_psum() - sign-extends a psum of run-time width into a wide vector;
//                 callers cast the result down to their accumulator width.
package mmu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int ACC_OFFSET = 8;
  localparam int EXT_W      = 128;

  function automatic logic [EXT_W-1:0] sext_psum(input logic [EXT_W-1:0] psum,
                                                 input int               psum_w);
    logic [EXT_W-1:0] r;
    for (int i = 0; i < EXT_W; i++) begin
      r[i] = (i < psum_w) ? psum[i] : psum[psum_w-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/mmu_deskew.sv
// mmu_deskew: triangular delay lines that realign the skewed column outputs
// of the systolic array. Column c is delayed by SYS_COL-1-c cycles, so the
// last column passes straight through and column 0 carries the longest delay.
// The {en, psum} pair of each column travels together.
// Ports:
//   clk, rstn          - clock, async active-low reset (clears valids)
//   en_in / psum_in    - skewed per-column valid and psum from the array
//   en_out / psum_out  - aligned per-column valid and psum
module mmu_deskew #(
  parameter int SYS_COL    = 16,
  parameter int PSUM_WIDTH = 32
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic [SYS_COL-1:0]                 en_in,
  input  logic [SYS_COL-1:0][PSUM_WIDTH-1:0] psum_in,
  output logic [SYS_COL-1:0]                 en_out,
  output logic [SYS_COL-1:0][PSUM_WIDTH-1:0] psum_out
);

  for (genvar c = 0; c < SYS_COL; c++) begin : g_col
    localparam int DLY = SYS_COL - 1 - c;
    if (DLY == 0) begin : g_pass
      assign en_out[c]   = en_in[c];
      assign psum_out[c] = psum_in[c];
    end else begin : g_dly
      logic [DLY-1:0]                 r_en;
      logic [DLY-1:0][PSUM_WIDTH-1:0] r_psum;

      // Shift register of depth DLY for this column's {en, psum}
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_en   <= '0;
          r_psum <= '0;
        end else begin
          r_en[0]   <= en_in[c];
          r_psum[0] <= psum_in[c];
          for (int k = 1; k < DLY; k++) begin
            r_en[k]   <= r_en[k-1];
            r_psum[k] <= r_psum[k-1];
          end
        end
      end

      assign en_out[c]   = r_en[DLY-1];
      assign psum_out[c] = r_psum[DLY-1];
    end
  end

endmodule

// File: rtl/mmu_accum.sv
// mmu_accum: output stage of the matrix-multiply unit. Deskews the column
// psums, accumulates row vectors over K passes in a register file and drains
// the finished rows over a valid/ready handshake.
// Ports:
//   clk, rstn              - clock, async active-low reset
//   start                  - one-cycle tile start; samples num_rows/num_passes
//   num_rows, num_passes   - tile configuration (1..ACC_DEPTH, >=1)
//   en_in, psum_in         - skewed per-column valid/psum from the array
//   out_valid/out_ready    - drain handshake
//   out_data, out_last     - drained row and final-row marker
//   busy, done, err        - status: active, end-of-tile pulse, sticky error
module mmu_accum
  import mmu_pkg::*;
#(
  parameter int  SYS_COL    = 16,
  parameter int  DATA_WIDTH = 16,
  parameter int  ACC_WIDTH  = DATA_WIDTH*2 + ACC_OFFSET,
  parameter int  ACC_DEPTH  = 16,
  parameter int  PASS_W     = 8,
  localparam int PSUM_WIDTH = DATA_WIDTH*2,
  localparam int ROW_W      = $clog2(ACC_DEPTH+1)
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               start,
  input  logic [ROW_W-1:0]                   num_rows,
  input  logic [PASS_W-1:0]                  num_passes,
  input  logic [SYS_COL-1:0]                 en_in,
  input  logic [SYS_COL-1:0][PSUM_WIDTH-1:0] psum_in,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [SYS_COL-1:0][ACC_WIDTH-1:0]  out_data,
  output logic                               out_last,
  output logic                               busy,
  output logic                               done,
  output logic                               err
);

  localparam int IDX_W = (ACC_DEPTH > 1) ? $clog2(ACC_DEPTH) : 1;
  typedef logic [ACC_WIDTH-1:0] acc_t;

  logic [SYS_COL-1:0]                 w_en_d;
  logic [SYS_COL-1:0][PSUM_WIDTH-1:0] w_psum_d;
  logic                               w_vvalid;
  logic                               w_skew_err;
  logic                               w_cfg_ok;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_row_ptr, r_drain_ptr, r_last_row, w_drain_ptr_nxt;
  logic [PASS_W-1:0]  r_pass_cnt, r_last_pass;
  logic               r_out_valid, r_out_last, r_done, r_err;

  logic w_start_ok, w_cfg_bad, w_acc_we, w_drop, w_hs, w_last_hs, w_row_wrap;

  acc_t r_acc     [ACC_DEPTH][SYS_COL];
  acc_t w_acc_new [SYS_COL];

  mmu_deskew #(
    .SYS_COL    (SYS_COL),
    .PSUM_WIDTH (PSUM_WIDTH)
  ) u_deskew (
    .clk      (clk),
    .rstn     (rstn),
    .en_in    (en_in),
    .psum_in  (psum_in),
    .en_out   (w_en_d),
    .psum_out (w_psum_d)
  );

  // Column 0 carries the vector valid; any other column disagreeing is a skew fault
  assign w_vvalid   = w_en_d[0];
  assign w_skew_err = |(w_en_d ^ {SYS_COL{w_en_d[0]}});
  assign w_cfg_ok   = (num_rows != '0) && (num_rows <= ROW_W'(ACC_DEPTH)) &&
                      (num_passes != '0);
  assign w_row_wrap = (r_row_ptr == r_last_row);

  // Next-state and per-cycle control decode
  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    w_cfg_bad   = 1'b0;
    w_acc_we    = 1'b0;
    w_drop      = 1'b0;
    w_hs        = 1'b0;
    w_last_hs   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_drop = w_vvalid;
        if (start) begin
          if (w_cfg_ok) begin
            w_start_ok  = 1'b1;
            w_state_nxt = ST_ACCUM;
          end else begin
            w_cfg_bad = 1'b1;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        w_acc_we = w_vvalid;
        if (w_vvalid && w_row_wrap && (r_pass_cnt == r_last_pass)) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_ACCUM;
        end
      end
      ST_DRAIN: begin
        w_drop = w_vvalid;
        w_hs   = out_ready;
        if (out_ready && r_out_last) begin
          w_last_hs   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Drain pointer: restarts with each tile, advances on every accepted row
  always_comb begin
    w_drain_ptr_nxt = r_drain_ptr;
    if (w_start_ok) begin
      w_drain_ptr_nxt = '0;
    end else if (w_hs) begin
      w_drain_ptr_nxt = r_drain_ptr + IDX_W'(1);
    end else begin
      w_drain_ptr_nxt = r_drain_ptr;
    end
  end

  // First pass overwrites the row, later passes add (modulo 2^ACC_WIDTH)
  always_comb begin
    for (int c = 0; c < SYS_COL; c++) begin
      w_acc_new[c] = ((r_pass_cnt == '0) ? acc_t'(0) : r_acc[r_row_ptr][c]) +
                     acc_t'(sext_psum(EXT_W'(w_psum_d[c]), PSUM_WIDTH));
    end
  end

  // FSM state, handshake outputs and sticky error
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_drain_ptr <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_ptr <= w_drain_ptr_nxt;
      r_out_valid <= (w_state_nxt == ST_DRAIN);
      r_out_last  <= (w_state_nxt == ST_DRAIN) && (w_drain_ptr_nxt == r_last_row);
      r_done      <= w_last_hs;
      // A new fault in the same cycle as a legal start still wins
      r_err       <= (r_err & ~w_start_ok) | w_cfg_bad | w_drop | w_skew_err;
    end
  end

  // Tile configuration, row pointer and pass counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_row_ptr   <= '0;
      r_pass_cnt  <= '0;
      r_last_row  <= '0;
      r_last_pass <= '0;
    end else if (w_start_ok) begin
      r_row_ptr   <= '0;
      r_pass_cnt  <= '0;
      r_last_row  <= IDX_W'(num_rows - ROW_W'(1));
      r_last_pass <= num_passes - PASS_W'(1);
    end else if (w_acc_we) begin
      if (w_row_wrap) begin
        r_row_ptr  <= '0;
        r_pass_cnt <= r_pass_cnt + PASS_W'(1);
      end else begin
        r_row_ptr  <= r_row_ptr + IDX_W'(1);
      end
    end
  end

  // Accumulator register file (contents need no reset)
  always_ff @(posedge clk) begin
    if (w_acc_we) begin
      for (int c = 0; c < SYS_COL; c++) begin
        r_acc[r_row_ptr][c] <= w_acc_new[c];
      end
    end
  end

  // Drain mux: registered storage selected by the registered drain pointer
  always_comb begin
    for (int c = 0; c < SYS_COL; c++) begin
      out_data[c] = r_acc[r_drain_ptr][c];
    end
  end

  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign done      = r_done;
  assign err       = r_err;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mmu_accum.sv
// tb_mmu_accum: scoreboard bench for mmu_accum with SYS_COL=4, ACC_DEPTH=8.
// Each test pushes the expected drained rows before feeding skewed psums;
// the drain task pops and compares on every handshake.
module tb_mmu_accum;

  logic                clk;
  logic                rstn;
  logic                start;
  logic [3:0]          num_rows;
  logic [7:0]          num_passes;
  logic [3:0]          en_in;
  logic [3:0][31:0]    psum_in;
  logic                out_valid;
  logic                out_ready;
  logic [3:0][39:0]    out_data;
  logic                out_last;
  logic                busy;
  logic                done;
  logic                err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0][31:0] stim_q[$];
  logic [3:0][39:0] exp_data_q[$];
  logic             exp_last_q[$];
  int               col_extra[4];

  mmu_accum #(
    .SYS_COL    (4),
    .DATA_WIDTH (16),
    .ACC_WIDTH  (40),
    .ACC_DEPTH  (8),
    .PASS_W     (8)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .num_rows   (num_rows),
    .num_passes (num_passes),
    .en_in      (en_in),
    .psum_in    (psum_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0][31:0] mkpsum(input int a, input int b, input int c, input int d);
    logic [3:0][31:0] r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  function automatic logic [3:0][39:0] mkrow(input int a, input int b, input int c, input int d);
    int v[4];
    logic signed [39:0] t;
    logic [3:0][39:0] r;
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int i = 0; i < 4; i++) begin
      t = v[i];
      r[i] = t;
    end
    return r;
  endfunction

  task automatic push_exp(input logic [3:0][39:0] row, input logic last);
    exp_data_q.push_back(row);
    exp_last_q.push_back(last);
  endtask

  // Pulse start for one cycle; entered and left at a negedge
  task automatic do_start(input logic [3:0] rows, input logic [7:0] passes);
    num_rows   = rows;
    num_passes = passes;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  // Drive stim_q with the array skew: column c of vector k at cycle k+c(+extra)
  task automatic feed();
    int n = stim_q.size();
    int span = 0;
    for (int c = 0; c < 4; c++) if (c + col_extra[c] > span) span = c + col_extra[c];
    for (int t = 0; t <= n - 1 + span; t++) begin
      en_in   = '0;
      psum_in = '0;
      for (int c = 0; c < 4; c++) begin
        int k = t - c - col_extra[c];
        if (k >= 0 && k < n) begin
          en_in[c]   = 1'b1;
          psum_in[c] = stim_q[k][c];
        end
      end
      @(negedge clk);
    end
    en_in   = '0;
    psum_in = '0;
    stim_q.delete();
  endtask

  // Drain against the scoreboard; mode 0 = always ready, 1 = ready toggles 1010
  task automatic drain(input int mode, input string name);
    int cyc = 0;
    logic pend = 1'b0;
    logic [3:0][39:0] held = '0;
    logic [3:0][39:0] ed;
    logic el;
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s drain_entry: out_valid=%b required 1", name, out_valid);
    end
    while (exp_data_q.size() > 0 && cyc < 200) begin
      out_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      n_tests++;
      if (done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s done_early: done=%b required 0", name, done);
      end
      if (out_valid === 1'b1) begin
        if (pend) begin
          n_tests++;
          if (out_data !== held) begin
            n_fail++;
            $display("FAIL %s hold: out_data=%h required %h", name, out_data, held);
          end
        end
        if (out_ready) begin
          ed = exp_data_q.pop_front();
          el = exp_last_q.pop_front();
          n_tests++;
          if (out_data !== ed) begin
            n_fail++;
            $display("FAIL %s data: out_data=%h required %h", name, out_data, ed);
          end
          n_tests++;
          if (out_last !== el) begin
            n_fail++;
            $display("FAIL %s last: out_last=%b required %b", name, out_last, el);
          end
          pend = 1'b0;
        end else begin
          pend = 1'b1;
          held = out_data;
        end
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    n_tests++;
    if (exp_data_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s timeout: %0d rows never drained, required 0", name, exp_data_q.size());
      exp_data_q.delete();
      exp_last_q.delete();
    end
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_pulse: done=%b busy=%b out_valid=%b required 1 0 0",
               name, done, busy, out_valid);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({busy, out_valid, out_last, done, err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: busy,valid,last,done,err=%b required 00000",
               {busy, out_valid, out_last, done, err});
    end
    rstn = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({busy, out_valid, done, err} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_release: busy,valid,done,err=%b required 0000",
               {busy, out_valid, done, err});
    end
  endtask

  task automatic test_single_pass();
    do_start(4'd2, 8'd1);
    push_exp(mkrow(1, 2, 3, 4), 1'b0);
    push_exp(mkrow(-1, -2, -3, -4), 1'b1);
    stim_q.push_back(mkpsum(1, 2, 3, 4));
    stim_q.push_back(mkpsum(-1, -2, -3, -4));
    feed();
    drain(0, "single_pass");
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pass err: err=%b required 0", err);
    end
  endtask

  // Starts in the cycle done is high from the previous tile
  task automatic test_multi_pass();
    logic [3:0][39:0] big;
    do_start(4'd3, 8'd4);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_in_done_cycle: busy=%b required 1", busy);
    end
    do_start(4'd0, 8'd1);
    n_tests++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_while_busy: err=%b busy=%b required 0 1", err, busy);
    end
    for (int i = 0; i < 4; i++) big[i] = 40'h01_FFFF_FFFC;
    for (int r = 0; r < 3; r++) push_exp(big, r == 2);
    for (int i = 0; i < 12; i++) stim_q.push_back(mkpsum(32'h7FFF_FFFF, 32'h7FFF_FFFF,
                                                       32'h7FFF_FFFF, 32'h7FFF_FFFF));
    feed();
    drain(0, "multi_pass");
  endtask

  task automatic test_back_to_back();
    do_start(4'd1, 8'd3);
    push_exp(mkrow(10, 10, 10, 10), 1'b1);
    stim_q.push_back(mkpsum(5, 5, 5, 5));
    stim_q.push_back(mkpsum(-2, -2, -2, -2));
    stim_q.push_back(mkpsum(7, 7, 7, 7));
    feed();
    drain(0, "back_to_back");
  endtask

  task automatic test_backpressure();
    do_start(4'd4, 8'd1);
    for (int r = 0; r < 4; r++) begin
      push_exp(mkrow(r*10+1, r*10+2, r*10+3, -(r*10+4)), r == 3);
      stim_q.push_back(mkpsum(r*10+1, r*10+2, r*10+3, -(r*10+4)));
    end
    feed();
    drain(1, "backpressure");
  endtask

  task automatic test_errors();
    // vvalid while idle is dropped and flagged
    stim_q.push_back(mkpsum(9, 9, 9, 9));
    feed();
    n_tests++;
    if (err !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_vvalid: err=%b busy=%b out_valid=%b required 1 0 0", err, busy, out_valid);
    end
    do_start(4'd1, 8'd1);
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL legal_start_clears: err=%b required 0", err);
    end
    push_exp(mkrow(3, -3, 0, 7), 1'b1);
    stim_q.push_back(mkpsum(3, -3, 0, 7));
    feed();
    drain(0, "after_idle_vvalid");
    @(negedge clk);
    do_start(4'd0, 8'd1);
    n_tests++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rows_zero: err=%b busy=%b required 1 0", err, busy);
    end
    do_start(4'd9, 8'd1);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rows_over_depth: busy=%b required 0", busy);
    end
    do_start(4'd2, 8'd1);
    n_tests++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_clears: err=%b busy=%b required 0 1", err, busy);
    end
    // Column 2 arrives one cycle late
    col_extra[2] = 1;
    stim_q.push_back(mkpsum(1, 1, 1, 1));
    feed();
    col_extra[2] = 0;
    n_tests++;
    if (err !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL skew_violation: err=%b busy=%b required 1 1", err, busy);
    end
  endtask

  // Entered with the FSM left in ACCUM by the skew test
  task automatic test_reset_mid_accum();
    rstn = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({busy, out_valid, done, err} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_mid: busy,valid,done,err=%b required 0000", {busy, out_valid, done, err});
    end
    rstn = 1'b1;
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_done: done=%b required 0", done);
    end
    do_start(4'd2, 8'd2);
    push_exp(mkrow(11, 21, 31, 41), 1'b0);
    push_exp(mkrow(99, 198, 297, 396), 1'b1);
    stim_q.push_back(mkpsum(10, 20, 30, 40));
    stim_q.push_back(mkpsum(100, 200, 300, 400));
    stim_q.push_back(mkpsum(1, 1, 1, 1));
    stim_q.push_back(mkpsum(-1, -2, -3, -4));
    feed();
    drain(1, "after_reset");
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset err: err=%b required 0", err);
    end
  endtask

  initial begin
    rstn       = 1'b0;
    start      = 1'b0;
    num_rows   = '0;
    num_passes = '0;
    en_in      = '0;
    psum_in    = '0;
    out_ready  = 1'b0;
    for (int c = 0; c < 4; c++) col_extra[c] = 0;
    @(negedge clk);
    test_reset();
    test_single_pass();
    test_multi_pass();
    test_back_to_back();
    test_backpressure();
    test_errors();
    test_reset_mid_accum();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
